// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core: TX/RX FIFOs, 16x oversampled RX, 1/2 stop bits.
// Optional parity is compiled in with `define UART_PARITY_EN.
module uart_core_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              stop2,
`ifdef UART_PARITY_EN
  input  logic              parity_en,
  input  logic              parity_odd,
`endif
  input  logic              tx_wr_en,
  input  logic [DATA_W-1:0] tx_wr_data,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              txd,
  input  logic              rxd,
  input  logic              rx_rd_en,
  output logic [DATA_W-1:0] rx_rd_data,
  output logic              rx_empty,
  output logic              rx_overrun,
  output logic              frame_err,
  output logic              parity_err,
  input  logic              err_clr,
  output logic              irq
);

  // Handshake: tx_wr_en is accepted only while !tx_full and rx_rd_en pops only
  // while !rx_empty; both act at the clock edge, rx_rd_data is the FWFT head.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W-1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;

  logic par_en_w, par_odd_w;
`ifdef UART_PARITY_EN
  assign par_en_w  = parity_en;
  assign par_odd_w = parity_odd;
`else
  assign par_en_w  = 1'b0;
  assign par_odd_w = 1'b0;
`endif

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp, tx_rp;
  logic [AW:0]       tx_cnt;
  logic              tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_full = (tx_cnt == FULL_CNT);
  assign tx_push = tx_wr_en && !tx_full;
  assign tx_head = tx_mem[tx_rp];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
  end

  // ---------------- TX FSM ----------------
  state_t            tx_state, tx_state_n;
  logic [DIV_W-1:0]  tx_presc, tx_div;
  logic [3:0]        tx_tcnt;
  logic [BW-1:0]     tx_bits;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_stop2, tx_par_on, tx_par_bit, tx_second;
  logic              tx_tick, tx_bit_end, tx_shift, tx_second_set, txd_n;

  assign tx_tick    = (tx_state != S_IDLE) && (tx_presc == tx_div);
  assign tx_bit_end = tx_tick && (tx_tcnt == 4'd15);
  assign tx_busy    = (tx_state != S_IDLE) || (tx_cnt != '0);

  always_comb begin
    tx_state_n    = tx_state;
    tx_pop        = 1'b0;
    tx_shift      = 1'b0;
    tx_second_set = 1'b0;
    case (tx_state)
      S_IDLE: if (tx_cnt != '0) begin
        tx_pop     = 1'b1;
        tx_state_n = S_START;
      end
      S_START: if (tx_bit_end) tx_state_n = S_DATA;
      S_DATA: if (tx_bit_end) begin
        if (tx_bits == LAST_BIT) tx_state_n = tx_par_on ? S_PARITY : S_STOP;
        else                     tx_shift   = 1'b1;
      end
      S_PARITY: if (tx_bit_end) tx_state_n = S_STOP;
      S_STOP: if (tx_bit_end) begin
        if (tx_stop2 && !tx_second) tx_second_set = 1'b1;
        else if (tx_cnt != '0) begin
          tx_pop     = 1'b1;
          tx_state_n = S_START;
        end else tx_state_n = S_IDLE;
      end
      default: tx_state_n = S_IDLE;
    endcase
    // txd is registered from the next state so the line changes with the state
    case (tx_state_n)
      S_START:  txd_n = 1'b0;
      S_DATA:   txd_n = tx_shift ? tx_sh[1] : tx_sh[0];
      S_PARITY: txd_n = tx_par_bit;
      default:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state   <= S_IDLE;
      tx_presc   <= '0;
      tx_div     <= '0;
      tx_tcnt    <= '0;
      tx_bits    <= '0;
      tx_sh      <= '0;
      tx_stop2   <= 1'b0;
      tx_par_on  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_second  <= 1'b0;
      txd        <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      txd      <= txd_n;
      if (tx_state == S_IDLE) begin
        tx_presc <= '0;
        tx_tcnt  <= '0;
      end else if (tx_tick) begin
        tx_presc <= '0;
        tx_tcnt  <= tx_tcnt + 4'd1;
      end else begin
        tx_presc <= tx_presc + DIV_W'(1);
      end
      if (tx_pop) begin
        tx_sh      <= tx_head;
        tx_div     <= baud_div;
        tx_stop2   <= stop2;
        tx_par_on  <= par_en_w;
        tx_par_bit <= (^tx_head) ^ par_odd_w;
        tx_bits    <= '0;
        tx_second  <= 1'b0;
      end else begin
        if (tx_shift) begin
          tx_sh   <= tx_sh >> 1;
          tx_bits <= tx_bits + BW'(1);
        end
        if (tx_second_set) tx_second <= 1'b1;
      end
    end
  end

  // ---------------- RX FSM ----------------
  state_t            rx_state, rx_state_n;
  logic              rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0]  rx_presc, rx_div;
  logic [3:0]        rx_tcnt;
  logic [BW-1:0]     rx_bits;
  logic [DATA_W-1:0] rx_sh, rx_push_word;
  logic              rx_par_on, rx_par_odd, rx_push_q;
  logic              rx_active, rx_tick, rx_sample;
  logic              rx_start, rx_shift, rx_push_req, frame_set, par_set;

  assign rx_active = (rx_state != S_IDLE) && (rx_state != S_BRK);
  assign rx_tick   = rx_active && (rx_presc == rx_div);
  assign rx_sample = rx_tick && (rx_tcnt == 4'd15);

  always_comb begin
    rx_state_n  = rx_state;
    rx_start    = 1'b0;
    rx_shift    = 1'b0;
    rx_push_req = 1'b0;
    frame_set   = 1'b0;
    par_set     = 1'b0;
    case (rx_state)
      S_IDLE: if (rx_prev && !rx_s) begin
        rx_start   = 1'b1;
        rx_state_n = S_START;
      end
      S_START: if (rx_sample) rx_state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA: if (rx_sample) begin
        rx_shift = 1'b1;
        if (rx_bits == LAST_BIT) rx_state_n = rx_par_on ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_sample) begin
        par_set    = rx_s ^ (^rx_sh) ^ rx_par_odd;
        rx_state_n = S_STOP;
      end
      S_STOP: if (rx_sample) begin
        if (rx_s) begin
          rx_push_req = 1'b1;
          rx_state_n  = S_IDLE;
        end else begin
          frame_set  = 1'b1;
          rx_state_n = S_BRK;
        end
      end
      S_BRK: if (rx_s) rx_state_n = S_IDLE;
      default: rx_state_n = S_IDLE;
    endcase
  end

  // The start edge preloads the tick counter to 8 so every sample lands on count 15
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= S_IDLE;
      rx_presc     <= '0;
      rx_div       <= '0;
      rx_tcnt      <= '0;
      rx_bits      <= '0;
      rx_sh        <= '0;
      rx_par_on    <= 1'b0;
      rx_par_odd   <= 1'b0;
      rx_push_q    <= 1'b0;
      rx_push_word <= '0;
    end else begin
      rx_meta   <= rxd;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      rx_state  <= rx_state_n;
      rx_push_q <= rx_push_req;
      if (rx_push_req) rx_push_word <= rx_sh;
      if (rx_start) begin
        rx_presc   <= '0;
        rx_tcnt    <= 4'd8;
        rx_div     <= baud_div;
        rx_bits    <= '0;
        rx_par_on  <= par_en_w;
        rx_par_odd <= par_odd_w;
      end else if (rx_tick) begin
        rx_presc <= '0;
        rx_tcnt  <= rx_tcnt + 4'd1;
      end else if (rx_active) begin
        rx_presc <= rx_presc + DIV_W'(1);
      end
      if (rx_shift) begin
        rx_sh   <= {rx_s, rx_sh[DATA_W-1:1]};
        rx_bits <= rx_bits + BW'(1);
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     rx_wp, rx_rp;
  logic [AW:0]       rx_cnt;
  logic              rx_full, rx_pop, rx_wr, ovr_set;

  assign rx_full    = (rx_cnt == FULL_CNT);
  assign rx_empty   = (rx_cnt == '0);
  assign rx_pop     = rx_rd_en && !rx_empty;
  assign rx_wr      = rx_push_q && (!rx_full || rx_pop);
  assign ovr_set    = rx_push_q && rx_full && !rx_pop;
  assign rx_rd_data = rx_empty ? '0 : rx_mem[rx_rp];

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp] <= rx_push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + AW'(1);
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + (AW+1)'(rx_wr) - (AW+1)'(rx_pop);
    end
  end

  // Sticky flags: a new event beats a simultaneous err_clr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      irq        <= 1'b0;
    end else begin
      rx_overrun <= ovr_set   | (rx_overrun & ~err_clr);
      frame_err  <= frame_set | (frame_err  & ~err_clr);
      parity_err <= par_set   | (parity_err & ~err_clr);
      irq        <= ~rx_empty | rx_overrun | frame_err | parity_err;
    end
  end

endmodule
